// File: rtl/ddr3_traffic_checker.sv
// Write/read-back loopback tester driving the user port of ddr3_memory_controller.
// Define LFSR_PATTERN_EN to use a 16-bit LFSR data pattern instead of index+1.
module ddr3_traffic_checker #(
  parameter int unsigned DQ_BITWIDTH           = 16,
  parameter int unsigned ADDRESS_BITWIDTH      = 15,
  parameter int unsigned BANK_ADDRESS_BITWIDTH = 3,
  parameter int unsigned NUM_OF_TEST_DATA      = 4,
  parameter int unsigned TIMEOUT_CYCLES        = 65535
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic                                              cmd_ready,
  input  logic [DQ_BITWIDTH-1:0]                            o_user_data,
  input  logic                                              o_user_data_valid,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            i_user_data,
  output logic                                              done,
  output logic                                              pass,
  output logic                                              timeout,
  output logic [15:0]                                       error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);

  localparam int unsigned AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int unsigned IW = $clog2(NUM_OF_TEST_DATA + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_OF_TEST_DATA - 1);
  localparam logic [IW-1:0] ALL_IDX    = IW'(NUM_OF_TEST_DATA);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t state, state_next;

  logic [IW-1:0]          wr_idx, rd_idx, ret_idx;
  logic [TW-1:0]          timer;
  logic                   cmp_err, cmp_mis, first_latched;
  logic [AW-1:0]          cmp_addr;
  logic [DQ_BITWIDTH-1:0] wr_pattern, exp_pattern;
  logic [15:0]            err_sum;
  logic                   wr_acc, rd_acc, busy, in_window, ret_ok, progress;
  logic                   start_go, timer_expire, abort, data_bad;

  always_comb begin
    wr_acc       = (state == S_WRITE) & cmd_ready;
    rd_acc       = (state == S_READ) & cmd_ready;
    busy         = (state == S_WRITE) | (state == S_READ) | (state == S_DRAIN);
    in_window    = ((state == S_READ) | (state == S_DRAIN)) & (ret_idx != ALL_IDX);
    ret_ok       = o_user_data_valid & in_window;
    progress     = wr_acc | rd_acc | o_user_data_valid;
    start_go     = start & ((state == S_IDLE) | (state == S_DONE));
    timer_expire = busy & ~progress & (timer == TIMER_LAST);
    data_bad     = o_user_data != exp_pattern;
    // Fold the compare still in flight into the count so pass sees the final return.
    err_sum      = (cmp_err && (error_count != '1)) ? error_count + 16'd1 : error_count;
  end

`ifdef LFSR_PATTERN_EN
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  logic [15:0] wr_lfsr, chk_lfsr;

  // Fibonacci x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (reset || start_go) begin
      wr_lfsr  <= LFSR_SEED;
      chk_lfsr <= LFSR_SEED;
    end else begin
      if (wr_acc) wr_lfsr <= lfsr_step(wr_lfsr);
      if (ret_ok) chk_lfsr <= lfsr_step(chk_lfsr);
    end
  end

  always_comb begin
    wr_pattern  = DQ_BITWIDTH'(wr_lfsr);
    exp_pattern = DQ_BITWIDTH'(chk_lfsr);
  end
`else
  always_comb begin
    wr_pattern  = DQ_BITWIDTH'(wr_idx) + DQ_BITWIDTH'(1);
    exp_pattern = DQ_BITWIDTH'(ret_idx) + DQ_BITWIDTH'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next          = state;
    abort               = 1'b0;
    write_enable        = 1'b0;
    read_enable         = 1'b0;
    i_user_data_address = '0;
    i_user_data         = '0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) state_next = S_WRITE;
      end
      S_WRITE: begin
        write_enable        = 1'b1;
        i_user_data_address = AW'(wr_idx);
        i_user_data         = wr_pattern;
        if (timer_expire) begin
          state_next = S_DONE;
          abort      = 1'b1;
        end else if (wr_acc && (wr_idx == LAST_IDX)) begin
          state_next = S_READ;
        end
      end
      S_READ: begin
        read_enable         = 1'b1;
        i_user_data_address = AW'(rd_idx);
        if (timer_expire) begin
          state_next = S_DONE;
          abort      = 1'b1;
        end else if (rd_acc && (rd_idx == LAST_IDX)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (ret_idx == ALL_IDX) begin
          state_next = S_DONE;
        end else if (timer_expire) begin
          state_next = S_DONE;
          abort      = 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || start_go) begin
      wr_idx              <= '0;
      rd_idx              <= '0;
      ret_idx             <= '0;
      timer               <= '0;
      cmp_err             <= 1'b0;
      cmp_mis             <= 1'b0;
      cmp_addr            <= '0;
      first_latched       <= 1'b0;
      error_count         <= '0;
      first_error_address <= '0;
      done                <= 1'b0;
      pass                <= 1'b0;
      timeout             <= 1'b0;
    end else begin
      if (wr_acc) wr_idx <= wr_idx + IW'(1);
      if (rd_acc) rd_idx <= rd_idx + IW'(1);
      if (ret_ok) ret_idx <= ret_idx + IW'(1);
      if (busy) timer <= progress ? '0 : timer + TW'(1);

      // Stray returns count as errors but never claim a first-error address.
      cmp_err  <= o_user_data_valid & (~in_window | data_bad);
      cmp_mis  <= ret_ok & data_bad;
      cmp_addr <= AW'(ret_idx);

      error_count <= err_sum;
      if (cmp_mis && !first_latched) begin
        first_error_address <= cmp_addr;
        first_latched       <= 1'b1;
      end

      if ((state_next == S_DONE) && (state != S_DONE)) begin
        done    <= 1'b1;
        timeout <= abort;
        pass    <= ~abort & (err_sum == '0);
      end
    end
  end

endmodule

// File: tb/tb_ddr3_traffic_checker.sv
// Directed bench for ddr3_traffic_checker with an in-order loopback memory model.
module tb_ddr3_traffic_checker;

  localparam int unsigned AW = 18;

  logic          clk = 1'b0;
  logic          reset, start, cmd_ready, o_user_data_valid;
  logic [15:0]   o_user_data;
  logic          write_enable, read_enable, done, pass, timeout;
  logic [AW-1:0] i_user_data_address, first_error_address;
  logic [15:0]   i_user_data, error_count;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  ddr3_traffic_checker #(
    .DQ_BITWIDTH(16),
    .ADDRESS_BITWIDTH(15),
    .BANK_ADDRESS_BITWIDTH(3),
    .NUM_OF_TEST_DATA(4),
    .TIMEOUT_CYCLES(100)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .cmd_ready(cmd_ready),
    .o_user_data(o_user_data),
    .o_user_data_valid(o_user_data_valid),
    .write_enable(write_enable),
    .read_enable(read_enable),
    .i_user_data_address(i_user_data_address),
    .i_user_data(i_user_data),
    .done(done),
    .pass(pass),
    .timeout(timeout),
    .error_count(error_count),
    .first_error_address(first_error_address)
  );

  logic [15:0]   mem [0:7];
  int            rq[$];
  int unsigned   wr_addr[$], wr_data[$], wr_cyc[$], rd_addr[$], rd_cyc[$];
  int unsigned   cyc = 0;
  int unsigned   last_rd_cyc, stall_bad, stall_seen;
  int            ready_mode, corrupt_addr;
  bit            ready_phase, no_return, stall_prev;
  logic [AW-1:0] held_addr;
  logic [15:0]   held_data;
  logic          held_we, held_re;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pat(input int unsigned i);
`ifdef LFSR_PATTERN_EN
    int unsigned v = 32'hACE1;
    int unsigned b;
    for (int unsigned k = 0; k < i; k++) begin
      b = ((v >> 0) ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
      v = (v >> 1) | (b << 15);
    end
    return v[15:0];
`else
    return 16'(i + 1);
`endif
  endfunction

  // One clock: drive inputs at negedge, log what the DUT presents, advance to next negedge.
  task automatic step();
    int a;
    cmd_ready   = (ready_mode == 0) ? 1'b1 : ready_phase;
    ready_phase = ~ready_phase;
    if (!no_return && rq.size() > 0) begin
      a = rq.pop_front();
      o_user_data_valid = 1'b1;
      o_user_data = mem[a[2:0]] ^ ((a == corrupt_addr) ? 16'h0001 : 16'h0000);
    end else begin
      o_user_data_valid = 1'b0;
      o_user_data = 16'h0000;
    end
    cyc++;
    if (stall_prev && (i_user_data_address !== held_addr || i_user_data !== held_data ||
                       write_enable !== held_we || read_enable !== held_re))
      stall_bad++;
    stall_prev = (write_enable | read_enable) & ~cmd_ready;
    if (stall_prev) stall_seen++;
    held_addr = i_user_data_address;
    held_data = i_user_data;
    held_we   = write_enable;
    held_re   = read_enable;
    if (write_enable && cmd_ready) begin
      mem[i_user_data_address[2:0]] = i_user_data;
      wr_addr.push_back(32'(i_user_data_address));
      wr_data.push_back(32'(i_user_data));
      wr_cyc.push_back(cyc);
    end
    if (read_enable && cmd_ready) begin
      rq.push_back(int'(i_user_data_address));
      rd_addr.push_back(32'(i_user_data_address));
      rd_cyc.push_back(cyc);
      last_rd_cyc = cyc;
    end
    @(negedge clk);
  endtask

  task automatic run_test(input int mode, input int corrupt, input bit noret, input string name);
    int unsigned n;
    ready_mode = mode;
    corrupt_addr = corrupt;
    no_return = noret;
    ready_phase = 1'b1;
    rq.delete(); wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
    rd_addr.delete(); rd_cyc.delete();
    stall_prev = 1'b0; stall_bad = 0; stall_seen = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({name, "_start_we"}, 32'(write_enable), 32'd1);
    chk({name, "_start_addr"}, 32'(i_user_data_address), 32'd0);
    chk({name, "_start_clr"}, 32'({done, pass, timeout, error_count}), 32'd0);
    n = 0;
    while (!done && n < 400) begin
      step();
      n++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_zero(input string name);
    chk({name, "_done"}, 32'(done), 32'd0);
    chk({name, "_pass"}, 32'(pass), 32'd0);
    chk({name, "_timeout"}, 32'(timeout), 32'd0);
    chk({name, "_errcnt"}, 32'(error_count), 32'd0);
    chk({name, "_firstaddr"}, 32'(first_error_address), 32'd0);
    chk({name, "_we"}, 32'(write_enable), 32'd0);
    chk({name, "_re"}, 32'(read_enable), 32'd0);
    chk({name, "_addr"}, 32'(i_user_data_address), 32'd0);
    chk({name, "_data"}, 32'(i_user_data), 32'd0);
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1; start = 1'b0; cmd_ready = 1'b0;
    o_user_data_valid = 1'b0; o_user_data = 16'h0000;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Ideal loopback.
    run_test(0, -1, 1'b0, "ideal");
    chk("ideal_nwr", wr_addr.size(), 32'd4);
    chk("ideal_nrd", rd_addr.size(), 32'd4);
    for (int unsigned i = 0; i < 4 && i < wr_addr.size() && i < rd_addr.size(); i++) begin
      chk($sformatf("ideal_wr_addr%0d", i), wr_addr[i], i);
      chk($sformatf("ideal_wr_data%0d", i), wr_data[i], 32'(pat(i)));
      chk($sformatf("ideal_rd_addr%0d", i), rd_addr[i], i);
    end
    if (wr_cyc.size() == 4 && rd_cyc.size() == 4) begin
      chk("ideal_wr_b2b", wr_cyc[3] - wr_cyc[0], 32'd3);
      chk("ideal_no_bubble", rd_cyc[0], wr_cyc[3] + 1);
      chk("ideal_rd_b2b", rd_cyc[3] - rd_cyc[0], 32'd3);
    end
`ifdef LFSR_PATTERN_EN
    if (wr_data.size() >= 2) begin
      chk("lfsr_first", wr_data[0], 32'hACE1);
      chk("lfsr_second", wr_data[1], 32'h5670);
    end
`else
    if (wr_data.size() >= 2) begin
      chk("cnt_first", wr_data[0], 32'd1);
      chk("cnt_second", wr_data[1], 32'd2);
    end
`endif
    chk("ideal_pass", 32'(pass), 32'd1);
    chk("ideal_errcnt", 32'(error_count), 32'd0);
    chk("ideal_timeout", 32'(timeout), 32'd0);

    // Stray return while DONE: counted, with one cycle of compare latency.
    o_user_data_valid = 1'b1;
    o_user_data = 16'h1234;
    @(negedge clk);
    o_user_data_valid = 1'b0;
    chk("stray_lat", 32'(error_count), 32'd0);
    @(negedge clk);
    chk("stray_cnt", 32'(error_count), 32'd1);
    chk("stray_done_held", 32'(done), 32'd1);

    // Backpressure: cmd_ready alternates.
    run_test(1, -1, 1'b0, "bp");
    chk("bp_nwr", wr_addr.size(), 32'd4);
    chk("bp_nrd", rd_addr.size(), 32'd4);
    chk("bp_stalls_seen", 32'(stall_seen > 0), 32'd1);
    chk("bp_stable", stall_bad, 32'd0);
    chk("bp_pass", 32'(pass), 32'd1);
    chk("bp_errcnt", 32'(error_count), 32'd0);

    // Single corruption at address 2.
    run_test(0, 2, 1'b0, "corrupt");
    chk("corrupt_errcnt", 32'(error_count), 32'd1);
    chk("corrupt_first", 32'(first_error_address), 32'd2);
    chk("corrupt_pass", 32'(pass), 32'd0);
    chk("corrupt_timeout", 32'(timeout), 32'd0);

    // No read data: progress timer aborts.
    run_test(0, -1, 1'b1, "noret");
    chk("noret_timeout", 32'(timeout), 32'd1);
    chk("noret_pass", 32'(pass), 32'd0);
    chk("noret_latency", cyc - last_rd_cyc, 32'd100);

    // Reset during READ, then a clean rerun.
    ready_mode = 0; no_return = 1'b0; corrupt_addr = -1;
    rq.delete();
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!read_enable && n < 20) begin
      step();
      n++;
    end
    chk("rst_reached_read", 32'(read_enable), 32'd1);
    step();
    reset = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    reset = 1'b0;
    @(negedge clk);
    run_test(0, -1, 1'b0, "rerun");
    chk("rerun_pass", 32'(pass), 32'd1);
    chk("rerun_errcnt", 32'(error_count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
